csr_access_unit: RTL

Sequencer between the execute stage and the CSR register file. Accepts one Zicsr instruction (CSRRW/S/C and immediate forms), checks legality, and runs the read-modify-write as separate read and write cycles. Side-effect-free reads and writes are skipped where the ISA requires it. Returns the old CSR value, or an illegal-instruction flag, to writeback over a valid/ready handshake.

---
 rtl/csr_pkg.sv | 36 +++
 rtl/csr_access_check.sv | 30 +++
 rtl/csr_access_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared types and address-field constants for the CSR access path.
package csr_pkg;

    typedef enum logic [2:0] {
        CsrRw  = 3'b001,
        CsrRs  = 3'b010,
        CsrRc  = 3'b011,
        CsrRwi = 3'b101,
        CsrRsi = 3'b110,
        CsrRci = 3'b111
    } csr_op_e;

    typedef enum logic [1:0] {
        PrivU = 2'd0,
        PrivS = 2'd1,
        PrivM = 2'd3
    } priv_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } csr_state_e;

    // Address fields: [11:10] == 2'b11 marks read-only space, [9:8] is the lowest privilege.
    localparam int unsigned CsrRoMsb   = 11;
    localparam int unsigned CsrRoLsb   = 10;
    localparam int unsigned CsrPrivMsb = 9;
    localparam int unsigned CsrPrivLsb = 8;

    function automatic logic op_is_rw(input logic [2:0] op);
        return (op == CsrRw) || (op == CsrRwi);
    endfunction

endpackage

// File: rtl/csr_access_check.sv
// Combinational legality and read/write-skip decode for one Zicsr instruction.
module csr_access_check
    import csr_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [11:0] addr_i,
    input  logic [1:0]  priv_i,
    input  logic        rs1_zero_i,
    input  logic [4:0]  zimm_i,
    input  logic        rd_zero_i,
    output logic        illegal_o,
    output logic        do_read_o,
    output logic        do_write_o
);

    logic bad_op;
    logic is_rw;

    always_comb begin
        bad_op     = (op_i[1:0] == 2'b00);
        is_rw      = op_is_rw(op_i);
        // Set/clear with a zero source must not write, so side effects stay untriggered.
        do_write_o = is_rw || (op_i[2] ? (zimm_i != 5'd0) : !rs1_zero_i);
        do_read_o  = !(is_rw && rd_zero_i);
        illegal_o  = bad_op
                   || (addr_i[CsrPrivMsb:CsrPrivLsb] > priv_i)
                   || (do_write_o && (addr_i[CsrRoMsb:CsrRoLsb] == 2'b11));
    end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one CSR read-modify-write as separate read and write cycles,
// returning the old value (or an illegal flag) over a valid/ready handshake.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clk_en_i,
    input  logic            flush_i,
    input  logic [1:0]      priv_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [11:0]     req_addr_i,
    input  logic [XLEN-1:0] req_rs1_data_i,
    input  logic [4:0]      req_zimm_i,
    input  logic            req_rs1_zero_i,
    input  logic            req_rd_zero_i,
    output logic            csr_rd_en_o,
    output logic            csr_wr_en_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wr_data_o,
    input  logic [XLEN-1:0] csr_rd_data_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_illegal_o
);

    csr_state_e      state_q, state_d;
    logic [1:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src_q, old_q, wr_data_q;
    logic            do_write_q, illegal_q;

    logic            chk_illegal, chk_do_read, chk_do_write;
    logic            accept;
    logic [1:0]      wr_op;
    logic [XLEN-1:0] req_src, wr_old, wr_src, wr_data_d;

    csr_access_check u_check (
        .op_i       (req_op_i),
        .addr_i     (req_addr_i),
        .priv_i     (priv_i),
        .rs1_zero_i (req_rs1_zero_i),
        .zimm_i     (req_zimm_i),
        .rd_zero_i  (req_rd_zero_i),
        .illegal_o  (chk_illegal),
        .do_read_o  (chk_do_read),
        .do_write_o (chk_do_write)
    );

    // Write data is registered on entry to WRITE: from zero when accepting a write-only
    // access in IDLE, from the value just read when leaving READ.
    always_comb begin
        req_src = req_op_i[2] ? {{(XLEN-5){1'b0}}, req_zimm_i} : req_rs1_data_i;
        if (state_q == StIdle) begin
            wr_op  = req_op_i[1:0];
            wr_old = '0;
            wr_src = req_src;
        end else begin
            wr_op  = op_q;
            wr_old = csr_rd_data_i;
            wr_src = src_q;
        end
        unique case (wr_op)
            2'b10:   wr_data_d = wr_old | wr_src;
            2'b11:   wr_data_d = wr_old & ~wr_src;
            default: wr_data_d = wr_src;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        csr_rd_en_o = 1'b0;
        csr_wr_en_o = 1'b0;
        rsp_valid_o = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_o = !flush_i;
                accept      = req_valid_i && !flush_i;
                if (accept) begin
                    state_d = chk_illegal ? StResp : (chk_do_read ? StRead : StWrite);
                end
            end
            StRead: begin
                csr_rd_en_o = 1'b1;
                state_d     = do_write_q ? StWrite : StResp;
            end
            StWrite: begin
                csr_wr_en_o = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A write already on the bus is committed; flush only drops what follows it.
        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else if (clk_en_i) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_q       <= 2'b00;
            addr_q     <= '0;
            src_q      <= '0;
            old_q      <= '0;
            wr_data_q  <= '0;
            do_write_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (clk_en_i) begin
            if (accept) begin
                op_q       <= req_op_i[1:0];
                addr_q     <= req_addr_i;
                src_q      <= req_src;
                old_q      <= '0;
                wr_data_q  <= wr_data_d;
                do_write_q <= chk_do_write;
                illegal_q  <= chk_illegal;
            end else if (state_q == StRead) begin
                old_q     <= csr_rd_data_i;
                wr_data_q <= wr_data_d;
            end
        end
    end

    assign csr_addr_o    = addr_q;
    assign csr_wr_data_o = wr_data_q;
    assign rsp_data_o    = old_q;
    assign rsp_illegal_o = (state_q == StResp) && illegal_q;

endmodule
